ram_copy_sequencer: RTL

Control sequencer for the memory-to-memory copy path. Source macro (fakeram45_64x7, 1-cycle read) feeds a fixed 3-stage register pipeline, which feeds the destination macro's write data.
The block drives the source read port and the destination write port. Each destination write is issued exactly when the matching read datum reaches the pipeline output, so a block of words is copied with no data buffering inside this block.

---
 rtl/ram_copy_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ram_copy_sequencer.sv
// ============================================================================
// Module      : ram_copy_sequencer
// Description : Read/write sequencer for a macro-to-macro copy through a fixed
//               register pipeline; destination writes align with read data.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ram_copy_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 7,
    parameter int READ_LAT   = 1,
    parameter int PIPE_DEPTH = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              src_ce_o,
    output logic              src_we_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic              dst_ce_o,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [DATA_W-1:0] dst_w_mask_o
);

    localparam int            LAT       = READ_LAT + PIPE_DEPTH;
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [ADDR_W:0]    cnt_q;
    logic [ADDR_W:0]    n_q;
    logic [ADDR_W-1:0]  sbase_q;
    logic [ADDR_W-1:0]  dbase_q;
    logic               busy_q;
    logic               done_q;
    logic               src_ce_q;
    logic               src_we_q;
    logic [ADDR_W-1:0]  src_addr_q;
    logic               dst_ce_q;
    logic               dst_we_q;
    logic [ADDR_W-1:0]  dst_addr_q;
    logic [DATA_W-1:0]  dst_w_mask_q;

    // Delay line carries {valid, word offset} from read issue to write slot
    logic [LAT-1:0]     dl_vld_q;
    logic [ADDR_W-1:0]  dl_off_q [LAT];

    logic [ADDR_W:0]    len_clamped;
    logic               push_vld;
    logic [ADDR_W-1:0]  push_off;
    logic [ADDR_W-1:0]  push_src_addr;

    assign len_clamped = (len_i > MAX_WORDS) ? MAX_WORDS : len_i;

    always_comb begin
        push_vld      = 1'b0;
        push_off      = '0;
        push_src_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i && (len_clamped != '0)) begin
                    push_vld      = 1'b1;
                    push_src_addr = src_base_i;
                end
            end
            S_READ: begin
                if (cnt_q < n_q) begin
                    push_vld      = 1'b1;
                    push_off      = cnt_q[ADDR_W-1:0];
                    push_src_addr = sbase_q + cnt_q[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            sbase_q    <= '0;
            dbase_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_ce_q   <= 1'b0;
            src_we_q   <= 1'b0;
            src_addr_q <= '0;
        end else begin
            src_we_q   <= 1'b0;
            done_q     <= 1'b0;
            src_ce_q   <= push_vld;
            src_addr_q <= push_src_addr;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sbase_q <= src_base_i;
                        dbase_q <= dst_base_i;
                        n_q     <= len_clamped;
                        cnt_q   <= CNT_ONE;
                        if (len_clamped == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (cnt_q < n_q) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Reads are contiguous, so an empty line means the last write has gone out
                    if (dl_vld_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dl_vld_q     <= '0;
            for (int k = 0; k < LAT; k++) begin
                dl_off_q[k] <= '0;
            end
            dst_ce_q     <= 1'b0;
            dst_we_q     <= 1'b0;
            dst_addr_q   <= '0;
            dst_w_mask_q <= '0;
        end else begin
            dl_vld_q    <= {dl_vld_q[LAT-2:0], push_vld};
            dl_off_q[0] <= push_off;
            for (int k = 1; k < LAT; k++) begin
                dl_off_q[k] <= dl_off_q[k-1];
            end
            dst_ce_q     <= dl_vld_q[LAT-1];
            dst_we_q     <= dl_vld_q[LAT-1];
            dst_addr_q   <= dl_vld_q[LAT-1] ? (dbase_q + dl_off_q[LAT-1]) : '0;
            dst_w_mask_q <= dl_vld_q[LAT-1] ? {DATA_W{1'b1}} : '0;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign src_ce_o     = src_ce_q;
    assign src_we_o     = src_we_q;
    assign src_addr_o   = src_addr_q;
    assign dst_ce_o     = dst_ce_q;
    assign dst_we_o     = dst_we_q;
    assign dst_addr_o   = dst_addr_q;
    assign dst_w_mask_o = dst_w_mask_q;

endmodule

`default_nettype wire
